// File: rtl/div_hilo_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : div_hilo_sequencer_if
// Description : Command / result bundle between a requester and the
//               div_hilo_sequencer control stage.
//               master : drives the divide command, observes the result.
//               slave  : the sequencer itself.
// Signals     : start, signed_op, dividend[WIDTH], divisor[WIDTH]  (command)
//               busy, done, div_by_zero, lo_out[WIDTH], hi_out[WIDTH] (result)
// Revision    : 1.0 - initial release
// ============================================================================
interface div_hilo_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] lo_out;
  logic [WIDTH-1:0] hi_out;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, div_by_zero, lo_out, hi_out
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, div_by_zero, lo_out, hi_out
  );
endinterface
`default_nettype wire

// File: rtl/div_hilo_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : div_hilo_sequencer
// Description : Multi-cycle control stage around a combinational restoring
//               divider. Latches a divide command, drives operand magnitudes
//               to the divider, waits SETTLE_CYCLES for the divider to settle,
//               then captures quotient/remainder, applies sign fixup and
//               presents LO (quotient) / HI (remainder).
// Ports       : clk            - system clock, rising edge
//               clr            - synchronous active-high reset
//               bus (slave)    - command in (start, signed_op, dividend,
//                                divisor), result out (busy, done,
//                                div_by_zero, lo_out, hi_out)
//               div_m          - divider M input, zero-extended |divisor|
//               div_q          - divider Q input, |dividend|
//               div_quotient   - divider quotient
//               div_remainder  - divider remainder (top bit unused)
// Options     : DIV_SHORTCUT_EN - when defined, |dividend| < |divisor|
//               completes immediately with LO=0, HI=dividend.
// Revision    : 1.0 - initial release
// ============================================================================
module div_hilo_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  wire logic             clk,
  input  wire logic             clr,
  div_hilo_sequencer_if.slave   bus,
  output logic [WIDTH:0]        div_m,
  output logic [WIDTH-1:0]      div_q,
  input  wire logic [WIDTH-1:0] div_quotient,
  input  wire logic [WIDTH:0]   div_remainder
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  // WAIT exits on the cycle the counter reads zero, so loading N-1 gives
  // exactly N cycles in WAIT.
  localparam logic [7:0] c_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  logic [1:0]       r_state;
  logic [7:0]       r_cnt;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_zero_pend;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH:0]   r_div_m;
  logic [WIDTH-1:0] r_div_q;

  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_divisor_zero;
  logic [WIDTH-1:0] w_rem;
  logic             w_unused_rem_msb;

  assign w_sign_a       = bus.signed_op & bus.dividend[WIDTH-1];
  assign w_sign_b       = bus.signed_op & bus.divisor[WIDTH-1];
  // Negation wraps modulo 2^WIDTH: the most negative value maps onto itself,
  // which is its exact unsigned magnitude.
  assign w_mag_a        = w_sign_a ? (~bus.dividend + 1'b1) : bus.dividend;
  assign w_mag_b        = w_sign_b ? (~bus.divisor + 1'b1) : bus.divisor;
  assign w_divisor_zero = (bus.divisor == '0);

  // Remainder magnitude always fits in WIDTH bits; the extra bit is unused.
  assign w_rem            = div_remainder[WIDTH-1:0];
  assign w_unused_rem_msb = div_remainder[WIDTH];

`ifdef DIV_SHORTCUT_EN
  logic w_shortcut;
  assign w_shortcut = (w_mag_a < w_mag_b);
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= c_IDLE;
      r_cnt       <= '0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_zero_pend <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_div_m     <= '0;
      r_div_q     <= '0;
    end else begin
      // busy/done are registered from the state, so they trail the FSM by
      // one edge; results are already stable when done rises.
      r_busy <= (r_state != c_IDLE);
      r_done <= 1'b0;

      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            if (w_divisor_zero) begin
              // Divider inputs deliberately left untouched on this path.
              r_lo        <= '1;
              r_hi        <= bus.dividend;
              r_zero_pend <= 1'b1;
              r_state     <= c_DONE;
            end else begin
              r_sign_a    <= w_sign_a;
              r_sign_b    <= w_sign_b;
              r_div_q     <= w_mag_a;
              r_div_m     <= {1'b0, w_mag_b};
              r_cnt       <= c_SETTLE_LOAD;
              r_zero_pend <= 1'b0;
              r_dbz       <= 1'b0;
`ifdef DIV_SHORTCUT_EN
              if (w_shortcut) begin
                // Quotient is zero and the remainder is the dividend itself,
                // already carrying the correct sign.
                r_lo    <= '0;
                r_hi    <= bus.dividend;
                r_state <= c_DONE;
              end else begin
                r_state <= c_WAIT;
              end
`else
              r_state <= c_WAIT;
`endif
            end
          end
        end

        c_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_state <= c_FIX;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        c_FIX: begin
          // Truncation toward zero; remainder follows the dividend's sign.
          r_lo    <= (r_sign_a ^ r_sign_b) ? (~div_quotient + 1'b1) : div_quotient;
          r_hi    <= r_sign_a ? (~w_rem + 1'b1) : w_rem;
          r_state <= c_DONE;
        end

        c_DONE: begin
          r_done  <= 1'b1;
          r_dbz   <= r_zero_pend;
          r_state <= c_IDLE;
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.lo_out      = r_lo;
  assign bus.hi_out      = r_hi;
  assign div_m           = r_div_m;
  assign div_q           = r_div_q;

endmodule
`default_nettype wire

// File: tb/tb_div_hilo_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_hilo_sequencer
// Description : Self-checking bench for div_hilo_sequencer with a behavioural
//               combinational divider and a queue-based scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_hilo_sequencer;
  localparam int W  = 32;
  localparam int ST = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  div_hilo_sequencer_if #(.WIDTH(W)) bus ();

  logic [W:0]   div_m;
  logic [W-1:0] div_q;
  logic [W-1:0] div_quotient;
  logic [W:0]   div_remainder;

  div_hilo_sequencer #(.WIDTH(W), .SETTLE_CYCLES(ST)) dut (
    .clk           (clk),
    .clr           (clr),
    .bus           (bus),
    .div_m         (div_m),
    .div_q         (div_q),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  // Behavioural stand-in for the combinational restoring divider.
  always_comb begin
    div_quotient  = '1;
    div_remainder = {1'b0, div_q};
    if (div_m[W-1:0] != '0) begin
      div_quotient  = div_q / div_m[W-1:0];
      div_remainder = {1'b0, div_q % div_m[W-1:0]};
    end
  end

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
    int           lat;
    int           t0;
    string        name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   busy_hist [0:1023];
  bit   prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < 1024) busy_hist[cyc] = bus.busy;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      if (prev_done) begin
        n_cmp++; n_bad++;
        $display("FAIL done_width: done high two cycles in a row at cycle %0d", cyc);
      end
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: done at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = q.pop_front();
        check({e.name, ".lo"},  bus.lo_out, e.lo);
        check({e.name, ".hi"},  bus.hi_out, e.hi);
        check({e.name, ".dbz"}, W'(bus.div_by_zero), W'(e.dbz));
        check({e.name, ".lat"}, W'(cyc - e.t0), W'(e.lat));
      end
    end
    prev_done = bus.done;
  end

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
    return (s && x[W-1]) ? (~x + 1'b1) : x;
  endfunction

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                        input logic edbz, output int t0);
    exp_t e;
    bit   quick;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.signed_op = s;
    @(posedge clk);
    #1;
    t0        = cyc;
    bus.start = 1'b0;
    quick     = (b == '0);
`ifdef DIV_SHORTCUT_EN
    if (b != '0 && mag(a, s) < mag(b, s)) quick = 1'b1;
`endif
    e.lo = elo; e.hi = ehi; e.dbz = edbz; e.t0 = t0; e.name = name;
    e.lat = quick ? 1 : ST + 2;
    q.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: no done within 40 cycles, expected lat %0d", name, e.lat);
      q.delete();
    end
  endtask

  initial begin
    int t0;
    clr           = 1'b1;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst.busy", W'(bus.busy), '0);
    check("rst.done", W'(bus.done), '0);
    check("rst.dbz",  W'(bus.div_by_zero), '0);
    check("rst.lo",   bus.lo_out, '0);
    check("rst.hi",   bus.hi_out, '0);
    check("rst.div_m", div_m[W-1:0] | W'(div_m[W]), '0);
    check("rst.div_q", div_q, '0);
    clr = 1'b0;

    // Unsigned 100/7 plus busy profile E0..E7
    run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, t0);
    for (int i = 0; i <= ST + 3; i++)
      check($sformatf("u100_7.busy_E%0d", i), W'(busy_hist[t0 + i]),
            W'((i >= 1 && i <= ST + 2) ? 1 : 0));

    run_op("s-7_2",  32'hFFFF_FFF9, 32'd2,        1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, t0);
    run_op("s7_-2",  32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, t0);
    run_op("s-100_-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,     32'hFFFF_FFFE, 1'b0, t0);
    run_op("u1234_0", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, t0);
    run_op("s1234_0", 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, t0);
    run_op("smin_-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b0, t0);
    run_op("umax_16", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0, t0);
    run_op("s-3_10",  32'hFFFF_FFFD, 32'd10, 1'b1, 32'h0, 32'hFFFF_FFFD, 1'b0, t0);

    // Mid-operation clear: start 50/5, ignored re-start at E2, clr at E3
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5; bus.signed_op = 1'b0;
    @(posedge clk);              // E0
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);              // after E1
    bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
    @(posedge clk);              // E2
    @(negedge clk);
    bus.start = 1'b0;
    clr       = 1'b1;
    @(posedge clk);              // E3
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);              // after E4
    check("clr.busy", W'(bus.busy), '0);
    check("clr.done", W'(bus.done), '0);
    check("clr.dbz",  W'(bus.div_by_zero), '0);
    check("clr.lo",   bus.lo_out, '0);
    check("clr.hi",   bus.hi_out, '0);
    check("clr.div_q", div_q, '0);
    repeat (10) @(negedge clk);  // monitor flags any stray done here
    run_op("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, t0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
